// File: rtl/ay_sound_if.sv
// Z80 I/O bus bundle between the CPU-side decode and the AY sound block.
interface ay_sound_if;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic [7:0]  dout;
  logic        dout_oe;

  modport master (output A, D, nIORQ, nRD, nWR, input dout, dout_oe);
  modport slave  (input A, D, nIORQ, nRD, nWR, output dout, dout_oe);
endinterface

// File: rtl/ay_sound.sv
// AY-3-8910-compatible PSG on Z80 ports FFFD (select/read) and BFFD (data write).
// Build option AY_LOG_VOL_EN: logarithmic (~3 dB/step) volume table instead of v*17.
module ay_sound #(
  parameter int CLK_DIV = 14
) (
  input  logic       clk,
  input  logic       nRESET,
  ay_sound_if.slave  bus,
  output logic [9:0] mix,
  output logic       pdm
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  function automatic logic [7:0] vol_curve(input logic [3:0] v);
`ifdef AY_LOG_VOL_EN
    logic [7:0] t;
    case (v)
      4'd0:    t = 8'd0;
      4'd1:    t = 8'd2;
      4'd2:    t = 8'd3;
      4'd3:    t = 8'd4;
      4'd4:    t = 8'd6;
      4'd5:    t = 8'd8;
      4'd6:    t = 8'd11;
      4'd7:    t = 8'd16;
      4'd8:    t = 8'd23;
      4'd9:    t = 8'd32;
      4'd10:   t = 8'd45;
      4'd11:   t = 8'd64;
      4'd12:   t = 8'd90;
      4'd13:   t = 8'd128;
      4'd14:   t = 8'd181;
      default: t = 8'd255;
    endcase
    return t;
`else
    return {v, v};
`endif
  endfunction

  // Prescaler: tick at the AY master rate, t8/t16 for tone and noise/envelope.
  logic [DIV_W-1:0] div_q;
  logic [3:0]       tick_cnt_q;
  logic             tick, t8, t16;
  assign tick = (div_q == DIV_LAST);
  assign t8   = tick & (tick_cnt_q[2:0] == 3'd7);
  assign t16  = tick & (tick_cnt_q == 4'hF);

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      div_q      <= '0;
      tick_cnt_q <= '0;
    end else if (tick) begin
      div_q      <= '0;
      tick_cnt_q <= tick_cnt_q + 4'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  logic sel_port, data_port, iowr, wr_stb;
  logic iowr_q, iowr_prev_q, wsel_q, wdat_q, env_restart_q;
  logic [7:0] d_q;
  logic [3:0] sel_q;
  logic [7:0] regs_q [16];
  logic       unused;

  assign sel_port  = bus.A[15] & bus.A[14] & ~bus.A[1];
  assign data_port = bus.A[15] & ~bus.A[14] & ~bus.A[1];
  assign iowr      = ~bus.nIORQ & ~bus.nWR & bus.nRD;
  assign wr_stb    = iowr_q & ~iowr_prev_q;
  assign unused    = ^{bus.A[13:2], bus.A[0]};

  // Bus fields are captured with the strobe so a long CPU cycle writes exactly once.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      iowr_q        <= 1'b0;
      iowr_prev_q   <= 1'b0;
      wsel_q        <= 1'b0;
      wdat_q        <= 1'b0;
      d_q           <= '0;
      sel_q         <= '0;
      env_restart_q <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      iowr_q        <= iowr;
      iowr_prev_q   <= iowr_q;
      wsel_q        <= sel_port;
      wdat_q        <= data_port;
      d_q           <= bus.D;
      env_restart_q <= wr_stb & wdat_q & (sel_q == 4'd13);
      if (wr_stb && wsel_q) sel_q <= d_q[3:0];
      if (wr_stb && wdat_q) regs_q[sel_q] <= d_q;
    end
  end

  logic [7:0] rd_mask;
  always_comb begin
    rd_mask = 8'hFF;
    case (sel_q)
      4'd1, 4'd3, 4'd5, 4'd13: rd_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: rd_mask = 8'h1F;
      default:                 rd_mask = 8'hFF;
    endcase
  end
  assign bus.dout    = (sel_q[3:1] == 3'b111) ? 8'hFF : (regs_q[sel_q] & rd_mask);
  assign bus.dout_oe = ~bus.nIORQ & ~bus.nRD & sel_port;

  logic [4:0]  np, ncnt_q;
  logic [16:0] lfsr_q;
  logic        noise;
  assign np    = (regs_q[6][4:0] == 5'd0) ? 5'd1 : regs_q[6][4:0];
  assign noise = lfsr_q[0];

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      ncnt_q <= '0;
      lfsr_q <= 17'h1;
    end else if (t16) begin
      if ({1'b0, ncnt_q} + 6'd1 >= {1'b0, np}) begin
        ncnt_q <= '0;
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        ncnt_q <= ncnt_q + 5'd1;
      end
    end
  end

  logic [15:0] ep, ecnt_q;
  logic [3:0]  env_cnt_q, env_hlvl_q, env_level;
  logic        env_att_q, env_hold_q;
  logic [7:0]  r13;
  assign r13       = regs_q[13];
  assign ep        = ({regs_q[12], regs_q[11]} == 16'd0) ? 16'd1 : {regs_q[12], regs_q[11]};
  assign env_level = env_hold_q ? env_hlvl_q : (env_att_q ? env_cnt_q : ~env_cnt_q);

  // Shape bits {C, Att, Alt, Hold} decide what happens when the step counter wraps.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      ecnt_q     <= '0;
      env_cnt_q  <= '0;
      env_hlvl_q <= '0;
      env_att_q  <= 1'b0;
      env_hold_q <= 1'b0;
    end else if (env_restart_q) begin
      ecnt_q     <= '0;
      env_cnt_q  <= '0;
      env_hold_q <= 1'b0;
      env_att_q  <= r13[2];
    end else if (t16 && !env_hold_q) begin
      if ({1'b0, ecnt_q} + 17'd1 >= {1'b0, ep}) begin
        ecnt_q    <= '0;
        env_cnt_q <= env_cnt_q + 4'd1;
        if (env_cnt_q == 4'hF) begin
          if (!r13[3]) begin
            env_hold_q <= 1'b1;
            env_hlvl_q <= 4'h0;
          end else if (r13[0]) begin
            env_hold_q <= 1'b1;
            env_hlvl_q <= {4{r13[2] ^ r13[1]}};
          end else if (r13[1]) begin
            env_att_q <= ~env_att_q;
          end
        end
      end else begin
        ecnt_q <= ecnt_q + 16'd1;
      end
    end
  end

  logic [2:0][7:0] lvl;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [11:0] tp_raw, tp, cnt_q;
      logic        tone_q, gate;
      logic [3:0]  v;
      assign tp_raw = {regs_q[2*gi+1][3:0], regs_q[2*gi]};
      assign tp     = (tp_raw == 12'd0) ? 12'd1 : tp_raw;
      assign gate   = (tone_q | regs_q[7][gi]) & (noise | regs_q[7][gi+3]);
      assign v      = regs_q[8+gi][4] ? env_level : regs_q[8+gi][3:0];
      assign lvl[gi] = gate ? vol_curve(v) : 8'd0;

      always_ff @(posedge clk) begin
        if (!nRESET) begin
          cnt_q  <= '0;
          tone_q <= 1'b0;
        end else if (t8) begin
          if ({1'b0, cnt_q} + 13'd1 >= {1'b0, tp}) begin
            cnt_q  <= '0;
            tone_q <= ~tone_q;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
      end
    end
  endgenerate

  logic [9:0]  mix_d, mix_q;
  logic [10:0] acc_q;
  assign mix_d = {2'b00, lvl[0]} + {2'b00, lvl[1]} + {2'b00, lvl[2]};

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      mix_q <= '0;
      acc_q <= '0;
    end else begin
      mix_q <= mix_d;
      acc_q <= {1'b0, acc_q[9:0]} + {1'b0, mix_q};
    end
  end

  assign mix = mix_q;
  assign pdm = acc_q[10];
endmodule
